// File: rtl/pp_pkg.sv
// Shared definitions for the pipelined RV32 fetch front end: constants, FSM
// encoding and small PC helpers.
package pp_pkg;

   localparam logic [31:0] NOP              = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } fetch_state_t;

   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/pp_fifo.sv
// Synchronous prefetch FIFO with push/pop/flush; flush empties it in one edge
// and wins over any push or pop in the same cycle.
module pp_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [WIDTH-1:0]         i_wdata,
   output logic [WIDTH-1:0]         o_rdata,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty,
   output logic                     o_full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == DEPTH_C);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/pp_fetch_unit.sv
// Instruction-fetch front end: fetch PC, single-outstanding I-mem request FSM
// and a prefetch FIFO of {pc, instr} pairs feeding IF/ID.
module pp_fetch_unit
   import pp_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_state_t   r_state;
   fetch_state_t   w_state_nxt;
   logic [31:0]    r_fpc;
   logic [31:0]    r_req_pc;
   logic [31:0]    w_fpc_nxt;
   logic [31:0]    w_req_pc_nxt;
   logic           w_push;
   logic           w_pop;
   logic [CW-1:0]  w_count;
   logic [CW-1:0]  w_count_after;
   logic           w_empty;
   logic           w_full;
   logic [63:0]    w_head;
   logic [31:0]    w_redir_pc;

   assign w_redir_pc    = word_align(redirect_pc);
   assign w_pop         = ~w_empty & out_ready;
   assign w_count_after = w_count + CW'(1) - CW'(w_pop);

   pp_fifo #(
      .WIDTH (64),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect),
      .i_wdata ({r_req_pc, imem_rdata}),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_fpc_nxt    = r_fpc;
      w_req_pc_nxt = r_req_pc;
      w_push       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (redirect) begin
               w_fpc_nxt = w_redir_pc;
            end else if (!w_full) begin
               w_state_nxt  = S_WAIT;
               w_req_pc_nxt = r_fpc;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               w_fpc_nxt   = w_redir_pc;
               w_state_nxt = imem_ack ? S_IDLE : S_DROP;
            end else if (imem_ack) begin
               w_push    = 1'b1;
               w_fpc_nxt = pc_inc(r_fpc);
               // Issue back-to-back only if a slot remains after this push/pop.
               if (w_count_after < DEPTH_C) begin
                  w_req_pc_nxt = pc_inc(r_fpc);
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_DROP: begin
            if (redirect) w_fpc_nxt = w_redir_pc;
            if (imem_ack) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_fpc   <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_fpc   <= w_fpc_nxt;
      end
   end

   always_ff @(posedge clk) begin
      r_req_pc <= w_req_pc_nxt;
   end

   assign imem_req  = (r_state != S_IDLE);
   assign imem_addr = imem_req ? r_req_pc : 32'h0;
   assign out_valid = ~w_empty;
   assign out_instr = out_valid ? w_head[31:0]  : NOP;
   assign out_pc    = out_valid ? w_head[63:32] : 32'h0;

endmodule

// File: tb/tb_pp_fetch_unit.sv
// Self-checking bench for pp_fetch_unit: scoreboard on the IF/ID stream,
// directed redirect/reset sequences and a table-driven wrap-around run.
module tb_pp_fetch_unit;
   import pp_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr, out_pc;

   logic        imem_req_w, out_valid_w;
   logic        out_ready_w = 1'b0;
   logic [31:0] imem_addr_w, imem_rdata_w, out_instr_w, out_pc_w;

   int          ack_mode = 0;
   logic        auto_ack = 1'b0, man_ack = 1'b0, seen = 1'b0;
   logic [31:0] auto_rdata = 32'h0, man_rdata = 32'h0;

   int          n_checks = 0;
   int          n_fail   = 0;
   bit          mon_en   = 1'b0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
   endfunction

   assign imem_ack     = (ack_mode != 0) ? auto_ack : man_ack;
   assign imem_rdata   = (ack_mode != 0) ? auto_rdata : man_rdata;
   assign imem_rdata_w = mem_word(imem_addr_w);

   pp_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc)
   );

   pp_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
      .clk(clk), .rst(rst),
      .imem_req(imem_req_w), .imem_addr(imem_addr_w),
      .imem_ack(1'b1), .imem_rdata(imem_rdata_w),
      .redirect(1'b0), .redirect_pc(32'h0),
      .out_valid(out_valid_w), .out_ready(out_ready_w),
      .out_instr(out_instr_w), .out_pc(out_pc_w)
   );

   // I-mem model: acks one cycle after it first sees a request.
   always @(posedge clk) begin
      #1;
      if (rst || ack_mode == 0) begin
         auto_ack = 1'b0;
         seen     = 1'b0;
      end else if (imem_req && seen) begin
         auto_ack   = 1'b1;
         auto_rdata = mem_word(imem_addr);
         seen       = 1'b0;
      end else begin
         auto_ack = 1'b0;
         seen     = imem_req;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (mon_en && !rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_extra: got pc %h expected no output", out_pc);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("sb_pc", out_pc, e);
            check("sb_instr", out_instr, mem_word(e));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      redirect = 1'b0;
      man_ack  = 1'b0;
      exp_q.delete();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      out_ready = 1'b0;
      check({name, "_pending"}, exp_q.size(), 0);
   endtask

   typedef struct {
      logic        rdy;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_ov;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t tbl[7];

   initial begin
      tbl[0] = '{1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0000_0000};
      tbl[1] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8};
      tbl[2] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8};
      tbl[3] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC};
      tbl[4] = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
      tbl[5] = '{1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000};
      tbl[6] = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};

      // Streaming with one-cycle ack latency
      ack_mode  = 1;
      out_ready = 1'b1;
      mon_en    = 1'b1;
      do_reset();
      check("rst_req", imem_req, 0);
      check("rst_addr", imem_addr, 0);
      check("rst_valid", out_valid, 0);
      check("rst_instr", out_instr, NOP);
      check("rst_pc", out_pc, 0);
      for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
      tick(); check("lat_c1_valid", out_valid, 0);
      tick(); check("lat_c2_valid", out_valid, 0);
      tick(); check("lat_c3_valid", out_valid, 1);
      drain("stream", 60);

      // Back-pressure: FIFO fills and requests stop
      out_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
      for (int i = 0; i < 10; i++) tick();
      check("full_req", imem_req, 0);
      check("full_valid", out_valid, 1);
      check("full_head_pc", out_pc, 0);
      out_ready = 1'b1;
      drain("release", 40);

      // Redirect while waiting without ack
      mon_en   = 1'b0;
      ack_mode = 0;
      do_reset();
      tick();
      check("r3_req0", imem_addr, 0);
      man_ack = 1'b1; man_rdata = mem_word(0);
      tick();
      man_ack = 1'b0;
      check("r3_head", out_pc, 0);
      check("r3_addr4", imem_addr, 4);
      tick();
      check("r3_addr4_stable", imem_addr, 4);
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      tick();
      redirect = 1'b0;
      check("r3_flush_valid", out_valid, 0);
      check("r3_flush_instr", out_instr, NOP);
      check("r3_drop_req", imem_req, 1);
      check("r3_drop_addr", imem_addr, 4);
      man_ack = 1'b1; man_rdata = 32'hBAD0_BAD0;
      tick();
      man_ack = 1'b0;
      check("r3_idle_req", imem_req, 0);
      check("r3_stale_valid", out_valid, 0);
      tick();
      check("r3_new_req", imem_req, 1);
      check("r3_new_addr", imem_addr, 32'h100);
      man_ack = 1'b1; man_rdata = mem_word(32'h100);
      tick();
      man_ack = 1'b0;
      check("r3_out_valid", out_valid, 1);
      check("r3_out_pc", out_pc, 32'h100);
      check("r3_out_instr", out_instr, mem_word(32'h100));

      // Redirect coincident with ack and pop
      out_ready = 1'b0;
      do_reset();
      tick();
      man_ack = 1'b1; man_rdata = mem_word(0);
      tick();
      check("r4_head", out_pc, 0);
      man_rdata = mem_word(4);
      out_ready = 1'b1;
      redirect  = 1'b1; redirect_pc = 32'h0000_0200;
      tick();
      redirect = 1'b0; man_ack = 1'b0;
      check("r4_valid", out_valid, 0);
      check("r4_pc", out_pc, 0);
      check("r4_req", imem_req, 0);
      tick();
      check("r4_new_addr", imem_addr, 32'h200);
      check("r4_new_req", imem_req, 1);
      man_ack = 1'b1; man_rdata = mem_word(32'h200);
      tick();
      man_ack = 1'b0;
      check("r4_out_pc", out_pc, 32'h200);
      check("r4_out_instr", out_instr, mem_word(32'h200));

      // Reset while a request is outstanding
      out_ready = 1'b1;
      do_reset();
      tick();
      man_ack = 1'b1; man_rdata = mem_word(0);
      tick();
      man_ack = 1'b0;
      check("r6_addr4", imem_addr, 4);
      tick();
      rst = 1'b1;
      tick();
      check("r6_rst_req", imem_req, 0);
      check("r6_rst_addr", imem_addr, 0);
      check("r6_rst_valid", out_valid, 0);
      rst = 1'b0; man_ack = 1'b1; man_rdata = 32'hBAD0_0BAD;
      tick();
      man_ack = 1'b0;
      check("r6_late_valid", out_valid, 0);
      check("r6_restart_req", imem_req, 1);
      check("r6_restart_addr", imem_addr, 0);
      man_ack = 1'b1; man_rdata = mem_word(0);
      tick();
      man_ack = 1'b0;
      check("r6_out_pc", out_pc, 0);
      check("r6_out_instr", out_instr, mem_word(0));

      // PC wrap with same-cycle ack, table-driven
      out_ready = 1'b0;
      do_reset();
      foreach (tbl[i]) begin
         out_ready_w = tbl[i].rdy;
         tick();
         check($sformatf("wrap%0d_req", i), imem_req_w, tbl[i].exp_req);
         check($sformatf("wrap%0d_addr", i), imem_addr_w, tbl[i].exp_addr);
         check($sformatf("wrap%0d_valid", i), out_valid_w, tbl[i].exp_ov);
         check($sformatf("wrap%0d_pc", i), out_pc_w, tbl[i].exp_pc);
         check($sformatf("wrap%0d_instr", i), out_instr_w,
               tbl[i].exp_ov ? mem_word(tbl[i].exp_pc) : NOP);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
